// File: rtl/scfifo_pkg.sv
// Shared constants and sizing helpers for the scfifo family.
// Read-mode selectors and depth/count width functions.
package scfifo_pkg;

  localparam int SA_FWFT   = 1;
  localparam int SA_NORMAL = 0;

  function automatic int depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int usedw_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/mlab_dp_ram.sv
// Simple dual-port MLAB array with a registered, enable-gated read port.
// Same-address read/write in one cycle is never issued by the owner.
module mlab_dp_ram
  import scfifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic [WIDTH-1:0]      din,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      dout
);

  (* ramstyle = "mlab" *)
  logic [WIDTH-1:0] mem [depth(ADDR_WIDTH)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    if (re) dout <= mem[raddr];
  end

endmodule

// File: rtl/scfifo_mlab_sa.sv
// Single-clock MLAB FIFO with show-ahead or normal read mode,
// threshold flags, used-words count and sticky error flags.
module scfifo_mlab_sa
  import scfifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int SHOW_AHEAD = SA_FWFT,
  parameter int AF_LVL     = depth(ADDR_WIDTH) - 2,
  parameter int AE_LVL     = 2
) (
  input  logic                clk,
  input  logic                sclr,
  input  logic                wreq,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                rreq,
  output logic [WIDTH-1:0]    rdata,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [ADDR_WIDTH:0] usedw,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = depth(ADDR_WIDTH);
  localparam int UW    = usedw_w(ADDR_WIDTH);
  localparam logic [UW-1:0] FULL_N = UW'(DEPTH);
  localparam logic [UW-1:0] AF_N   = UW'(AF_LVL);
  localparam logic [UW-1:0] AE_N   = UW'(AE_LVL);
  localparam bit FWFT = (SHOW_AHEAD != SA_NORMAL);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [UW-1:0]         mcount;
  logic [UW-1:0]         mcount_n;
  logic [UW-1:0]         usedw_n;
  logic                  ovalid;
  logic                  ovalid_n;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  fetch;
  logic                  rzero;
  logic [WIDTH-1:0]      dout;

  always_comb begin
    wr_acc   = wreq & ~full;
    rd_acc   = rreq & ~empty;
    fetch    = rd_acc;
    ovalid_n = 1'b0;
    if (FWFT) begin
      // refill the output stage when it is idle or being consumed
      fetch    = (mcount != '0) & (~ovalid | rreq);
      ovalid_n = fetch | (ovalid & ~rd_acc);
    end
    usedw_n  = usedw + UW'(wr_acc) - UW'(rd_acc);
    mcount_n = mcount + UW'(wr_acc) - UW'(fetch);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wptr         <= '0;
      rptr         <= '0;
      mcount       <= '0;
      usedw        <= '0;
      ovalid       <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_N == '0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rzero        <= 1'b1;
    end else begin
      if (wr_acc) wptr <= wptr + ADDR_WIDTH'(1);
      if (fetch)  rptr <= rptr + ADDR_WIDTH'(1);
      mcount       <= mcount_n;
      usedw        <= usedw_n;
      ovalid       <= ovalid_n;
      empty        <= FWFT ? ~ovalid_n : (usedw_n == '0);
      full         <= (usedw_n == FULL_N);
      almost_empty <= (usedw_n <= AE_N);
      almost_full  <= (usedw_n >= AF_N);
      if (wreq & full)  overflow  <= 1'b1;
      if (rreq & empty) underflow <= 1'b1;
      if (fetch)        rzero     <= 1'b0;
    end
  end

  mlab_dp_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .din   (wdata),
    .waddr (wptr),
    .we    (wr_acc & ~sclr),
    .re    (fetch & ~sclr),
    .raddr (rptr),
    .dout  (dout)
  );

  // the array has no reset, so mask it until the first post-reset read
  assign rdata = rzero ? '0 : dout;

endmodule

// File: tb/tb_scfifo_mlab_sa.sv
// Bench for scfifo_mlab_sa: normal (idx 0) and show-ahead (idx 1)
// instances share stimulus and are checked against a queue model.
module tb_scfifo_mlab_sa;

  logic       clk = 1'b0;
  logic       sclr;
  logic       wreq;
  logic       rreq;
  logic [7:0] wdata;

  logic [7:0] rd  [2];
  logic [4:0] uw  [2];
  logic       em  [2];
  logic       fu  [2];
  logic       ae  [2];
  logic       af  [2];
  logic       ovf [2];
  logic       unf [2];

  int checks = 0;
  int errors = 0;

  // model: per-mode list of words with the edge that accepted them
  logic [7:0] md  [2][16];
  int         mwe [2][16];
  int         hd  [2];
  int         cnt [2];
  logic       mov [2];
  logic       mun [2];
  logic [7:0] exp_rd [2];
  int         t = 0;
  bit         mvalid = 1'b0;

  always #5 clk = ~clk;

  scfifo_mlab_sa #(
    .WIDTH(8), .ADDR_WIDTH(4), .SHOW_AHEAD(0),
    .AF_LVL(14), .AE_LVL(2)
  ) u_nm (
    .clk(clk), .sclr(sclr), .wreq(wreq), .wdata(wdata),
    .rreq(rreq), .rdata(rd[0]), .empty(em[0]), .full(fu[0]),
    .almost_empty(ae[0]), .almost_full(af[0]), .usedw(uw[0]),
    .overflow(ovf[0]), .underflow(unf[0])
  );

  scfifo_mlab_sa #(
    .WIDTH(8), .ADDR_WIDTH(4), .SHOW_AHEAD(1),
    .AF_LVL(14), .AE_LVL(2)
  ) u_sa (
    .clk(clk), .sclr(sclr), .wreq(wreq), .wdata(wdata),
    .rreq(rreq), .rdata(rd[1]), .empty(em[1]), .full(fu[1]),
    .almost_empty(ae[1]), .almost_full(af[1]), .usedw(uw[1]),
    .overflow(ovf[1]), .underflow(unf[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // a show-ahead word is visible once its write edge is at least one edge old
  function automatic bit visible(input int m, input int now);
    if (cnt[m] == 0) return 1'b0;
    if (m == 0) return 1'b1;
    return mwe[m][hd[m]] <= now - 1;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit vp;
      bit wok;
      bit rok;
      vp = visible(m, t);
      if (sclr) begin
        cnt[m] = 0;
        hd[m] = 0;
        mov[m] = 1'b0;
        mun[m] = 1'b0;
        exp_rd[m] = 8'h00;
      end else begin
        wok = wreq && (cnt[m] < 16);
        rok = rreq && vp;
        if (wreq && cnt[m] == 16) mov[m] = 1'b1;
        if (rreq && !vp) mun[m] = 1'b1;
        if (rok) begin
          if (m == 0) exp_rd[m] = md[m][hd[m]];
          hd[m] = (hd[m] + 1) % 16;
          cnt[m]--;
        end
        if (wok) begin
          md[m][(hd[m] + cnt[m]) % 16] = wdata;
          mwe[m][(hd[m] + cnt[m]) % 16] = t + 1;
          cnt[m]++;
        end
      end
    end
    t++;
    if (sclr) mvalid = 1'b1;
    if (visible(1, t)) exp_rd[1] = md[1][hd[1]];
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d usedw", m), 32'(uw[m]), cnt[m]);
        chk($sformatf("m%0d empty", m), 32'(em[m]),
            32'(!visible(m, t)));
        chk($sformatf("m%0d full", m), 32'(fu[m]), 32'(cnt[m] == 16));
        chk($sformatf("m%0d aempty", m), 32'(ae[m]), 32'(cnt[m] <= 2));
        chk($sformatf("m%0d afull", m), 32'(af[m]), 32'(cnt[m] >= 14));
        chk($sformatf("m%0d ovf", m), 32'(ovf[m]), 32'(mov[m]));
        chk($sformatf("m%0d unf", m), 32'(unf[m]), 32'(mun[m]));
        chk($sformatf("m%0d rdata", m), 32'(rd[m]), 32'(exp_rd[m]));
      end
    end
  end

  task automatic step(input bit w, input logic [7:0] d,
                      input bit r, input bit s);
    wreq = w;
    wdata = d;
    rreq = r;
    sclr = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sclr = 1'b1;
    wreq = 1'b0;
    rreq = 1'b0;
    wdata = 8'h00;

    step(0, 8'h00, 0, 1);
    for (int m = 0; m < 2; m++) begin
      chk("rst usedw", 32'(uw[m]), 0);
      chk("rst empty", 32'(em[m]), 1);
      chk("rst full", 32'(fu[m]), 0);
      chk("rst aempty", 32'(ae[m]), 1);
      chk("rst afull", 32'(af[m]), 0);
      chk("rst ovf", 32'(ovf[m]), 0);
      chk("rst unf", 32'(unf[m]), 0);
      chk("rst rdata", 32'(rd[m]), 0);
    end

    step(1, 8'h11, 0, 0);
    chk("sa empty c1", 32'(em[1]), 1);
    chk("nm empty c1", 32'(em[0]), 0);
    step(0, 8'h00, 0, 0);
    chk("sa empty c2", 32'(em[1]), 0);
    chk("sa rdata c2", 32'(rd[1]), 32'h11);
    chk("sa usedw c2", 32'(uw[1]), 1);
    step(0, 8'h00, 1, 0);
    chk("sa empty c3", 32'(em[1]), 1);
    chk("sa usedw c3", 32'(uw[1]), 0);
    chk("nm rdata c3", 32'(rd[0]), 32'h11);

    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    for (int m = 0; m < 2; m++) begin
      chk("fill full", 32'(fu[m]), 1);
      chk("fill usedw", 32'(uw[m]), 16);
    end
    step(1, 8'h99, 0, 0);
    for (int m = 0; m < 2; m++) chk("fill ovf", 32'(ovf[m]), 1);
    step(1, 8'h77, 1, 0);
    for (int m = 0; m < 2; m++) begin
      chk("fullrw usedw", 32'(uw[m]), 15);
      chk("fullrw full", 32'(fu[m]), 0);
    end
    chk("fullrw nm rdata", 32'(rd[0]), 32'h00);
    chk("fullrw sa rdata", 32'(rd[1]), 32'h01);
    for (int i = 1; i < 16; i++) step(0, 8'h00, 1, 0);
    for (int m = 0; m < 2; m++) begin
      chk("drain usedw", 32'(uw[m]), 0);
      chk("drain empty", 32'(em[m]), 1);
      chk("drain unf", 32'(unf[m]), 0);
    end
    chk("drain nm rdata", 32'(rd[0]), 32'h0F);

    step(0, 8'h00, 0, 1);
    step(1, 8'hA5, 0, 0);
    step(1, 8'h5A, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("nm rd1", 32'(rd[0]), 32'hA5);
    chk("sa rd1", 32'(rd[1]), 32'h5A);
    step(0, 8'h00, 1, 0);
    chk("nm rd2", 32'(rd[0]), 32'h5A);
    step(0, 8'h00, 1, 0);
    chk("nm rd3 hold", 32'(rd[0]), 32'h5A);
    for (int m = 0; m < 2; m++) chk("rd3 unf", 32'(unf[m]), 1);

    for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0);
    for (int m = 0; m < 2; m++) chk("mid usedw", 32'(uw[m]), 5);
    step(1, 8'hEE, 0, 1);
    for (int m = 0; m < 2; m++) begin
      chk("mid rst usedw", 32'(uw[m]), 0);
      chk("mid rst empty", 32'(em[m]), 1);
      chk("mid rst rdata", 32'(rd[m]), 0);
      chk("mid rst unf", 32'(unf[m]), 0);
    end
    step(0, 8'h00, 0, 0);
    for (int m = 0; m < 2; m++) chk("mid rst drop", 32'(uw[m]), 0);

    for (int i = 0; i < 200; i++) begin
      bit w;
      bit r;
      w = ($urandom_range(0, 99) < 55) && cnt[0] < 10 && cnt[1] < 10;
      r = $urandom_range(0, 99) < 50;
      step(w, 8'($urandom), r, 0);
    end

    for (int i = 0; i < 400; i++) begin
      int pw;
      bit w;
      bit r;
      bit s;
      pw = ((i / 100) % 2 == 0) ? 80 : 20;
      w = $urandom_range(0, 99) < pw;
      r = $urandom_range(0, 99) < (100 - pw);
      s = $urandom_range(0, 127) == 0;
      step(w, 8'($urandom), r, s);
    end

    step(0, 8'h00, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
